// File: rtl/quant_param_gen_pkg.sv
// quant_pkg: FSM states, quant/dequant scale tables, chroma QP map and QP bound helper for quant_param_gen
package quant_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DIV} state_t;
    localparam logic [7:0] RND_INTRA = 8'd171;
    localparam logic [7:0] RND_INTER = 8'd85;
    function automatic logic [14:0] quant_scale(input logic [2:0] r);
        return r == 3'd0 ? 15'd26214 : r == 3'd1 ? 15'd23302 : r == 3'd2 ? 15'd20560 :
               r == 3'd3 ? 15'd18396 : r == 3'd4 ? 15'd16384 : 15'd14564;
    endfunction
    function automatic logic [6:0] lev_scale(input logic [2:0] r);
        return r == 3'd0 ? 7'd40 : r == 3'd1 ? 7'd45 : r == 3'd2 ? 7'd51 :
               r == 3'd3 ? 7'd57 : r == 3'd4 ? 7'd64 : 7'd72;
    endfunction
    function automatic logic [5:0] chroma_map(input logic [3:0] i);
        case (i)
            4'd0: return 6'd29;
            4'd1: return 6'd30;
            4'd2: return 6'd31;
            4'd3: return 6'd32;
            4'd4, 4'd5: return 6'd33;
            4'd6, 4'd7: return 6'd34;
            4'd8, 4'd9: return 6'd35;
            4'd10, 4'd11: return 6'd36;
            default: return 6'd37;
        endcase
    endfunction
    function automatic int qp_max(input int bd);
        return 51 + 6 * (bd - 8);
    endfunction
endpackage

// File: rtl/quant_param_gen_if.sv
// quant_param_gen_if: recompute request/status and query port bundle for quant_param_gen
interface quant_param_gen_if #(parameter int QP_W = 7);
    logic            start_i;
    logic [QP_W-1:0] qp_i;
    logic signed [4:0] cb_off_i;
    logic signed [4:0] cr_off_i;
    logic            busy_o;
    logic            params_vld_o;
    logic            q_req_i;
    logic [1:0]      q_ch_i;
    logic [1:0]      q_size_i;
    logic            q_inv_i;
    logic            q_intra_i;
    logic            q_vld_o;
    logic [19:0]     scale_o;
    logic [31:0]     offset_o;
    logic [5:0]      shift_o;
    modport master (
        output start_i, qp_i, cb_off_i, cr_off_i, q_req_i, q_ch_i, q_size_i, q_inv_i, q_intra_i,
        input  busy_o, params_vld_o, q_vld_o, scale_o, offset_o, shift_o
    );
    modport slave (
        input  start_i, qp_i, cb_off_i, cr_off_i, q_req_i, q_ch_i, q_size_i, q_inv_i, q_intra_i,
        output busy_o, params_vld_o, q_vld_o, scale_o, offset_o, shift_o
    );
endinterface

// File: rtl/quant_param_gen_qp_divmod6.sv
// qp_divmod6: iterative subtract-by-6 engine producing QP/6 (per) and QP%6 (rem)
module qp_divmod6 #(
    parameter int QP_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [QP_W-1:0] din,
    output logic [QP_W-3:0] per,
    output logic [2:0]      rem,
    output logic            done
);
    logic [QP_W-1:0] r;
    assign done = r < QP_W'(6);
    assign rem  = r[2:0];
    // load a fresh QP, then take one 6 off per step until the remainder is below 6
    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= '0;
            per <= '0;
        end else if (load) begin
            r   <= din;
            per <= '0;
        end else if (step && !done) begin
            r   <= r - QP_W'(6);
            per <= per + 1'b1;
        end
    end
endmodule

// File: rtl/quant_param_gen.sv
// quant_param_gen: per-channel QP/6, QP%6 table with registered forward/inverse scale query; CHROMA_QP_MAP_EN adds the HEVC 4:2:0 chroma QP map
module quant_param_gen
    import quant_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int NUM_CH    = 3,
    parameter int QP_W      = 7
) (
    input logic clk,
    input logic rst,
    quant_param_gen_if.slave bus
);
    localparam int QMAX  = qp_max(BIT_DEPTH);
    localparam int PER_W = QP_W - 2;
    state_t state, state_nx;
    logic [1:0] ch;
    logic [QP_W-1:0] qp_q, qp_clip, div_din;
    logic signed [4:0] cb_q, cr_q, off;
    logic signed [QP_W+1:0] sum;
    logic [PER_W+2:0] tbl [4];
    logic div_load, div_step, div_done, tbl_we, pvld, last;
    logic [PER_W-1:0] div_per, q_per;
    logic [2:0] div_rem, q_rem;
    logic ch_ok, q_vld;
    logic [5:0] fwd_sh, inv_sh, sh_nx, shift_q;
    logic [7:0] rnd;
    logic [19:0] scale_nx, scale_q;
    logic [31:0] off_nx, off_q;

    assign last    = ch == 2'(NUM_CH - 1);
    assign off     = ch == 2'd1 ? cb_q : cr_q;
    assign sum     = $signed({2'b00, qp_q}) + (QP_W+2)'(off);
    assign qp_clip = sum[QP_W+1] ? '0 : sum > $signed((QP_W+2)'(QMAX)) ? QP_W'(QMAX) : sum[QP_W-1:0];

`ifdef CHROMA_QP_MAP_EN
    logic [QP_W-1:0] map_q, qp_map;
    logic map_ph;
    assign qp_map  = qp_clip < QP_W'(30) ? qp_clip : qp_clip > QP_W'(43) ? qp_clip - QP_W'(6) :
                     QP_W'(chroma_map(4'(qp_clip - QP_W'(30))));
    assign div_din = ch == 2'd0 ? qp_q : map_q;
    // chroma spends one LOAD cycle registering the mapped QP before the divider is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            map_q  <= '0;
            map_ph <= 1'b0;
        end else if (state == LOAD) begin
            map_q  <= qp_map;
            map_ph <= !div_load;
        end
    end
`else
    assign div_din = ch == 2'd0 ? qp_q : qp_clip;
`endif

    qp_divmod6 #(.QP_W(QP_W)) u_div (
        .clk(clk), .rst(rst), .load(div_load), .step(div_step), .din(div_din),
        .per(div_per), .rem(div_rem), .done(div_done)
    );

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    // next state and divider/table controls
    always_comb begin
        state_nx = state;
        div_load = 1'b0;
        div_step = 1'b0;
        tbl_we   = 1'b0;
        case (state)
            IDLE: state_nx = bus.start_i ? LOAD : IDLE;
            LOAD: begin
`ifdef CHROMA_QP_MAP_EN
                div_load = ch == 2'd0 || map_ph;
`else
                div_load = 1'b1;
`endif
                state_nx = div_load ? DIV : LOAD;
            end
            DIV: begin
                div_step = 1'b1;
                tbl_we   = div_done;
                state_nx = !div_done ? DIV : last ? IDLE : LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // request capture, channel sequencing and {per,rem} table
    always_ff @(posedge clk) begin
        if (rst) begin
            ch   <= '0;
            qp_q <= '0;
            cb_q <= '0;
            cr_q <= '0;
            pvld <= 1'b0;
            tbl  <= '{default: '0};
        end else begin
            if (state == IDLE && bus.start_i) begin
                qp_q <= bus.qp_i;
                cb_q <= bus.cb_off_i;
                cr_q <= bus.cr_off_i;
                ch   <= '0;
                pvld <= 1'b0;
            end
            if (tbl_we) begin
                tbl[ch] <= {div_per, div_rem};
                ch      <= last ? ch : ch + 2'd1;
                pvld    <= last;
            end
        end
    end

    assign {q_per, q_rem} = tbl[bus.q_ch_i];
    assign ch_ok    = int'(bus.q_ch_i) < NUM_CH;
    assign fwd_sh   = 6'(27 - BIT_DEPTH) + 6'(q_per) - 6'(bus.q_size_i);
    assign inv_sh   = 6'(BIT_DEPTH - 7) + 6'(bus.q_size_i);
    assign rnd      = bus.q_intra_i ? RND_INTRA : RND_INTER;
    assign scale_nx = !ch_ok ? '0 : bus.q_inv_i ? 20'(lev_scale(q_rem)) << q_per : 20'(quant_scale(q_rem));
    assign off_nx   = !ch_ok ? '0 : bus.q_inv_i ? 32'd1 << (inv_sh - 6'd1) : 32'(rnd) << (fwd_sh - 6'd9);
    assign sh_nx    = !ch_ok ? '0 : bus.q_inv_i ? inv_sh : fwd_sh;

    // one-cycle query pipeline; results hold while no request is made
    always_ff @(posedge clk) begin
        if (rst) begin
            q_vld   <= 1'b0;
            scale_q <= '0;
            off_q   <= '0;
            shift_q <= '0;
        end else begin
            q_vld <= bus.q_req_i;
            if (bus.q_req_i) begin
                scale_q <= scale_nx;
                off_q   <= off_nx;
                shift_q <= sh_nx;
            end
        end
    end

    assign bus.busy_o       = state != IDLE;
    assign bus.params_vld_o = pvld;
    assign bus.q_vld_o      = q_vld;
    assign bus.scale_o      = scale_q;
    assign bus.offset_o     = off_q;
    assign bus.shift_o      = shift_q;
endmodule

// File: tb/tb_quant_param_gen.sv
// tb_quant_param_gen: directed vectors over three configurations (8b/1ch, 8b/3ch, 10b/1ch)
module tb_quant_param_gen;
    logic clk, rst, start, q_req, q_inv, q_intra;
    logic [6:0] qp;
    logic signed [4:0] cb, cr;
    logic [1:0] q_ch, q_size;
    int sel;
    logic busy, pvld, qvld;
    logic [19:0] scale;
    logic [31:0] offset;
    logic [5:0] shift;
    int n_vec = 0, n_err = 0;

    typedef struct {int s; int ch; int size; int inv; int intra; int sc; int off; int sh;} vec_t;
    vec_t v[12];

    quant_param_gen_if #(.QP_W(7)) a0 (), a1 (), a2 ();
    quant_param_gen #(.BIT_DEPTH(8),  .NUM_CH(1), .QP_W(7)) d0 (.clk(clk), .rst(rst), .bus(a0));
    quant_param_gen #(.BIT_DEPTH(8),  .NUM_CH(3), .QP_W(7)) d1 (.clk(clk), .rst(rst), .bus(a1));
    quant_param_gen #(.BIT_DEPTH(10), .NUM_CH(1), .QP_W(7)) d2 (.clk(clk), .rst(rst), .bus(a2));

    assign a0.start_i = start && sel == 0;
    assign a1.start_i = start && sel == 1;
    assign a2.start_i = start && sel == 2;
    assign a0.qp_i = qp; assign a1.qp_i = qp; assign a2.qp_i = qp;
    assign a0.cb_off_i = cb; assign a1.cb_off_i = cb; assign a2.cb_off_i = cb;
    assign a0.cr_off_i = cr; assign a1.cr_off_i = cr; assign a2.cr_off_i = cr;
    assign a0.q_req_i = q_req; assign a1.q_req_i = q_req; assign a2.q_req_i = q_req;
    assign a0.q_ch_i = q_ch; assign a1.q_ch_i = q_ch; assign a2.q_ch_i = q_ch;
    assign a0.q_size_i = q_size; assign a1.q_size_i = q_size; assign a2.q_size_i = q_size;
    assign a0.q_inv_i = q_inv; assign a1.q_inv_i = q_inv; assign a2.q_inv_i = q_inv;
    assign a0.q_intra_i = q_intra; assign a1.q_intra_i = q_intra; assign a2.q_intra_i = q_intra;

    always_comb begin
        busy   = sel == 0 ? a0.busy_o : sel == 1 ? a1.busy_o : a2.busy_o;
        pvld   = sel == 0 ? a0.params_vld_o : sel == 1 ? a1.params_vld_o : a2.params_vld_o;
        qvld   = sel == 0 ? a0.q_vld_o : sel == 1 ? a1.q_vld_o : a2.q_vld_o;
        scale  = sel == 0 ? a0.scale_o : sel == 1 ? a1.scale_o : a2.scale_o;
        offset = sel == 0 ? a0.offset_o : sel == 1 ? a1.offset_o : a2.offset_o;
        shift  = sel == 0 ? a0.shift_o : sel == 1 ? a1.shift_o : a2.shift_o;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endfunction

    task automatic do_start(input int s, input int q, input int c_b, input int c_r);
        sel = s; qp = 7'(q); cb = 5'(c_b); cr = 5'(c_r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_vld(output int n);
        logic both;
        both = 1'b0;
        n = 0;
        while (!pvld && n < 300) begin
            @(posedge clk); #1;
            n++;
            both |= busy && pvld;
        end
        chk("vld_timeout", pvld, 1);
        chk("busy_and_vld", both, 0);
    endtask

    task automatic query(input string nm, input int s, input int c, input int sz, input int inv,
                         input int intra, input int e_sc, input int e_off, input int e_sh);
        sel = s; q_ch = 2'(c); q_size = 2'(sz); q_inv = 1'(inv); q_intra = 1'(intra); q_req = 1'b1;
        @(posedge clk); #1;
        q_req = 1'b0;
        chk({nm, "_vld"}, qvld, 1);
        chk({nm, "_scale"}, scale, e_sc);
        chk({nm, "_offset"}, offset, e_off);
        chk({nm, "_shift"}, shift, e_sh);
    endtask

    initial begin
        int n;
        v[0]  = '{0, 0, 0, 0, 1, 18396, 2801664, 23};
        v[1]  = '{0, 0, 3, 0, 0, 18396, 174080, 20};
        v[2]  = '{0, 0, 0, 1, 0, 912, 1, 1};
        v[3]  = '{0, 0, 2, 1, 1, 912, 4, 3};
        v[4]  = '{0, 1, 0, 1, 0, 0, 0, 0};
        v[5]  = '{1, 0, 1, 0, 1, 18396, 22413312, 26};
`ifdef CHROMA_QP_MAP_EN
        v[6]  = '{1, 1, 0, 1, 0, 7296, 1, 1};
        v[7]  = '{1, 2, 0, 0, 0, 14564, 2785280, 24};
`else
        v[6]  = '{1, 1, 0, 1, 0, 14592, 1, 1};
        v[7]  = '{1, 2, 0, 0, 0, 18396, 5570560, 25};
`endif
        v[8]  = '{1, 3, 0, 0, 1, 0, 0, 0};
        v[9]  = '{2, 0, 1, 1, 0, 58368, 8, 4};
        v[10] = '{2, 0, 2, 0, 0, 18396, 5570560, 25};
        v[11] = '{2, 0, 0, 0, 1, 18396, 44826624, 27};

        rst = 1'b1; start = 1'b0; q_req = 1'b0; q_inv = 1'b0; q_intra = 1'b0;
        qp = '0; cb = '0; cr = '0; q_ch = '0; q_size = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pvld", pvld, 0);
        chk("rst_qvld", qvld, 0);
        chk("rst_scale", scale, 0);
        chk("rst_offset", offset, 0);
        chk("rst_shift", shift, 0);
        rst = 1'b0;

        do_start(0, 27, 0, 0);
        chk("qp27_busy", busy, 1);
        wait_vld(n);
        chk("qp27_cycles", n, 6);
        chk("qp27_idle", busy, 0);
        do_start(1, 51, 12, -12);
        wait_vld(n);
        chk("ch3_cycles", n, 28);
        do_start(2, 63, 0, 0);
        wait_vld(n);
        chk("bd10_cycles", n, 12);

        for (int i = 0; i < 12; i++)
            query($sformatf("vec%0d", i), v[i].s, v[i].ch, v[i].size, v[i].inv, v[i].intra,
                  v[i].sc, v[i].off, v[i].sh);
        @(posedge clk); #1;
        chk("hold_vld", qvld, 0);
        chk("hold_shift", shift, 27);
        chk("hold_offset", offset, 44826624);

        do_start(0, 0, 0, 0);
        chk("qp0_pvld_clr", pvld, 0);
        wait_vld(n);
        chk("qp0_cycles", n, 2);
        query("qp0_inv32", 0, 0, 3, 1, 0, 40, 8, 4);

        do_start(1, 20, 0, 0);
        @(posedge clk); #1;
        qp = 7'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_ign_busy", busy, 1);
`ifdef CHROMA_QP_MAP_EN
        query("stale_ch2", 1, 2, 0, 1, 0, 2304, 1, 1);
`else
        query("stale_ch2", 1, 2, 0, 1, 0, 3648, 1, 1);
`endif
        chk("stale_pvld", pvld, 0);
        wait_vld(n);
        query("qp20_ch0", 1, 0, 0, 1, 0, 408, 1, 1);
        query("qp20_ch2", 1, 2, 0, 0, 1, 20560, 1400832, 22);

        do_start(0, 51, 0, 0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("div_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_pvld", pvld, 0);
        chk("abort_scale", scale, 0);
        chk("abort_offset", offset, 0);
        chk("abort_shift", shift, 0);
        rst = 1'b0;
        query("zero_d0", 0, 0, 0, 0, 1, 26214, 175104, 19);
        query("zero_d1", 1, 0, 0, 1, 0, 40, 1, 1);
        do_start(0, 27, 0, 0);
        wait_vld(n);
        chk("restart_cycles", n, 6);
        query("restart_q", 0, 0, 0, 0, 1, 18396, 2801664, 23);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
